// File: rtl/miriscv_decode_pkg.sv
// rtl/miriscv_decode_pkg.sv - shared decode/issue types for the miriscv scoreboard
package miriscv_decode_pkg;

    typedef struct packed {
        logic [4:0] rd;
        logic       load;
    } sb_lsu_tag_t;

    localparam int SB_LSU_DEPTH_MAX = 4;

    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        reg_onehot = 32'b1 << r;
    endfunction

endpackage

// File: rtl/miriscv_scoreboard_if.sv
// rtl/miriscv_scoreboard_if.sv - decode/issue and completion signals of the scoreboard
interface miriscv_scoreboard_if;

    logic        dec_valid_i;
    logic        dec_ready_o;
    logic        kill_i;
    logic [4:0]  dec_rs1_addr_i;
    logic [4:0]  dec_rs2_addr_i;
    logic        dec_rs1_re_i;
    logic        dec_rs2_re_i;
    logic [4:0]  dec_rd_addr_i;
    logic        dec_wb_we_i;
    logic        dec_load_i;
    logic        dec_mem_req_i;
    logic        dec_mdu_req_i;
    logic        lsu_done_i;
    logic        mdu_done_i;
    logic        stall_o;
    logic [31:0] pending_o;
    logic [2:0]  lsu_cnt_o;
    logic        mdu_busy_o;

    modport master (
        output dec_valid_i, kill_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_re_i,
               dec_rs2_re_i, dec_rd_addr_i, dec_wb_we_i, dec_load_i, dec_mem_req_i,
               dec_mdu_req_i, lsu_done_i, mdu_done_i,
        input  dec_ready_o, stall_o, pending_o, lsu_cnt_o, mdu_busy_o
    );

    modport slave (
        input  dec_valid_i, kill_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_re_i,
               dec_rs2_re_i, dec_rd_addr_i, dec_wb_we_i, dec_load_i, dec_mem_req_i,
               dec_mdu_req_i, lsu_done_i, mdu_done_i,
        output dec_ready_o, stall_o, pending_o, lsu_cnt_o, mdu_busy_o
    );

endinterface

// File: rtl/miriscv_sb_fifo.sv
// rtl/miriscv_sb_fifo.sv - in-order LSU transaction tag FIFO
module miriscv_sb_fifo
    import miriscv_decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  sb_lsu_tag_t push_tag_i,
    input  logic        pop_i,
    output sb_lsu_tag_t head_o,
    output logic [2:0]  count_o
);

    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    sb_lsu_tag_t mem [SB_LSU_DEPTH_MAX];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        do_push;
    logic        do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign do_pop  = pop_i && (count_o != 3'd0);
    assign do_push = push_i && ((count_o != FULL_CNT) || do_pop);
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_o <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? 2'd0 : wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? 2'd0 : rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 3'd1;
                2'b01:   count_o <= count_o - 3'd1;
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_tag_i;
    end

endmodule

// File: rtl/miriscv_scoreboard.sv
// rtl/miriscv_scoreboard.sv - issue hazard scoreboard; MIRISCV_SCOREBOARD_BYPASS_EN enables same-cycle retire bypass
module miriscv_scoreboard
    import miriscv_decode_pkg::*;
#(
    parameter int LSU_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    miriscv_scoreboard_if.slave  sb
);

    localparam logic [2:0] LSU_FULL_CNT = 3'(LSU_DEPTH);

    logic [31:0] pending_q;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] retire_vec;
    logic        mdu_busy_q;
    logic [4:0]  mdu_rd_q;
    sb_lsu_tag_t head;
    sb_lsu_tag_t push_tag;
    logic [2:0]  lsu_cnt;
    logic        lsu_pop, mdu_ret, byp_lsu, byp_mdu;
    logic        raw1, raw2, waw, lsu_full, mdu_conf;
    logic        ready, issue, tag_load;

    assign lsu_pop = sb.lsu_done_i && (lsu_cnt != 3'd0);
    assign mdu_ret = sb.mdu_done_i && mdu_busy_q;

    always_comb begin
        clr_vec = '0;
        if (lsu_pop && head.load) clr_vec = clr_vec | reg_onehot(head.rd);
        if (mdu_ret)              clr_vec = clr_vec | reg_onehot(mdu_rd_q);
    end

`ifdef MIRISCV_SCOREBOARD_BYPASS_EN
    assign retire_vec = clr_vec;
    assign byp_lsu    = lsu_pop;
    assign byp_mdu    = mdu_ret;
`else
    // Hazards see registered state only, keeping done pulses off the ready path
    assign retire_vec = '0;
    assign byp_lsu    = 1'b0;
    assign byp_mdu    = 1'b0;
`endif

    assign raw1 = sb.dec_rs1_re_i && (sb.dec_rs1_addr_i != 5'd0) &&
                  pending_q[sb.dec_rs1_addr_i] && !retire_vec[sb.dec_rs1_addr_i];
    assign raw2 = sb.dec_rs2_re_i && (sb.dec_rs2_addr_i != 5'd0) &&
                  pending_q[sb.dec_rs2_addr_i] && !retire_vec[sb.dec_rs2_addr_i];
    assign waw  = sb.dec_wb_we_i && (sb.dec_rd_addr_i != 5'd0) &&
                  pending_q[sb.dec_rd_addr_i] && !retire_vec[sb.dec_rd_addr_i];
    assign lsu_full = sb.dec_mem_req_i && (lsu_cnt == LSU_FULL_CNT) && !byp_lsu;
    assign mdu_conf = sb.dec_mdu_req_i && mdu_busy_q && !byp_mdu;

    assign ready    = !(raw1 || raw2 || waw || lsu_full || mdu_conf);
    assign issue    = sb.dec_valid_i && ready && !sb.kill_i;
    assign tag_load = sb.dec_load_i && sb.dec_wb_we_i && (sb.dec_rd_addr_i != 5'd0);
    assign push_tag = {sb.dec_rd_addr_i, tag_load};

    always_comb begin
        set_vec = '0;
        if (issue && sb.dec_mem_req_i && tag_load)
            set_vec = set_vec | reg_onehot(sb.dec_rd_addr_i);
        if (issue && sb.dec_mdu_req_i && sb.dec_wb_we_i && (sb.dec_rd_addr_i != 5'd0))
            set_vec = set_vec | reg_onehot(sb.dec_rd_addr_i);
    end

    // Set is applied after clear so a re-issued writer keeps its register busy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            mdu_busy_q <= 1'b0;
            mdu_rd_q   <= 5'd0;
        end else begin
            pending_q <= ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
            if (issue && sb.dec_mdu_req_i) begin
                mdu_busy_q <= 1'b1;
                mdu_rd_q   <= sb.dec_rd_addr_i;
            end else if (mdu_ret) begin
                mdu_busy_q <= 1'b0;
            end
        end
    end

    miriscv_sb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (issue && sb.dec_mem_req_i),
        .push_tag_i (push_tag),
        .pop_i      (lsu_pop),
        .head_o     (head),
        .count_o    (lsu_cnt)
    );

    assign sb.dec_ready_o = ready;
    assign sb.stall_o     = sb.dec_valid_i && !ready;
    assign sb.pending_o   = pending_q;
    assign sb.lsu_cnt_o   = lsu_cnt;
    assign sb.mdu_busy_o  = mdu_busy_q;

endmodule

// File: tb/tb_miriscv_scoreboard.sv
// tb/tb_miriscv_scoreboard.sv - self-checking bench for miriscv_scoreboard
module tb_miriscv_scoreboard;

`ifdef MIRISCV_SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    miriscv_scoreboard_if sb_if ();

    miriscv_scoreboard #(
        .LSU_DEPTH (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       observe = {31'd0, sb_if.dec_ready_o};
            1:       observe = {31'd0, sb_if.stall_o};
            2:       observe = sb_if.pending_o;
            3:       observe = {29'd0, sb_if.lsu_cnt_o};
            default: observe = {31'd0, sb_if.mdu_busy_o};
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic expect_state(input string tag, input logic ready, input logic [31:0] pend,
                                input logic [2:0] cnt, input logic busy);
        #1;
        sb_push({tag, ".ready"}, 0, {31'd0, ready});
        sb_push({tag, ".stall"}, 1, {31'd0, sb_if.dec_valid_i & ~ready});
        sb_push({tag, ".pending"}, 2, pend);
        sb_push({tag, ".lsu_cnt"}, 3, {29'd0, cnt});
        sb_push({tag, ".mdu_busy"}, 4, {31'd0, busy});
        sb_drain();
    endtask

    task automatic idle();
        sb_if.dec_valid_i    = 1'b0;
        sb_if.kill_i         = 1'b0;
        sb_if.dec_rs1_addr_i = 5'd0;
        sb_if.dec_rs2_addr_i = 5'd0;
        sb_if.dec_rs1_re_i   = 1'b0;
        sb_if.dec_rs2_re_i   = 1'b0;
        sb_if.dec_rd_addr_i  = 5'd0;
        sb_if.dec_wb_we_i    = 1'b0;
        sb_if.dec_load_i     = 1'b0;
        sb_if.dec_mem_req_i  = 1'b0;
        sb_if.dec_mdu_req_i  = 1'b0;
        sb_if.lsu_done_i     = 1'b0;
        sb_if.mdu_done_i     = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic drv_load(input logic [4:0] rd);
        sb_if.dec_valid_i   = 1'b1;
        sb_if.dec_mem_req_i = 1'b1;
        sb_if.dec_load_i    = 1'b1;
        sb_if.dec_wb_we_i   = 1'b1;
        sb_if.dec_rd_addr_i = rd;
    endtask

    task automatic drv_store();
        sb_if.dec_valid_i    = 1'b1;
        sb_if.dec_mem_req_i  = 1'b1;
        sb_if.dec_rs1_addr_i = 5'd10;
        sb_if.dec_rs1_re_i   = 1'b1;
    endtask

    task automatic drv_mdu(input logic [4:0] rd);
        sb_if.dec_valid_i   = 1'b1;
        sb_if.dec_mdu_req_i = 1'b1;
        sb_if.dec_wb_we_i   = 1'b1;
        sb_if.dec_rd_addr_i = rd;
    endtask

    task automatic drv_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        sb_if.dec_valid_i    = 1'b1;
        sb_if.dec_wb_we_i    = 1'b1;
        sb_if.dec_rd_addr_i  = rd;
        sb_if.dec_rs1_addr_i = rs1;
        sb_if.dec_rs1_re_i   = 1'b1;
        sb_if.dec_rs2_addr_i = rs2;
        sb_if.dec_rs2_re_i   = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle();
        #1;
        expect_state("reset", 1'b1, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // load x5, then add x6,x5,x0 waits for the load to retire
        next_cycle(); drv_load(5'd5);
        expect_state("raw.ld", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); drv_alu(5'd6, 5'd5, 5'd0);
        expect_state("raw.st1", 1'b0, 32'h20, 3'd1, 1'b0);
        next_cycle(); drv_alu(5'd6, 5'd5, 5'd0);
        expect_state("raw.st2", 1'b0, 32'h20, 3'd1, 1'b0);
        next_cycle(); drv_alu(5'd6, 5'd5, 5'd0); sb_if.lsu_done_i = 1'b1;
        expect_state("raw.done", BYP, 32'h20, 3'd1, 1'b0);
        next_cycle(); drv_alu(5'd6, 5'd5, 5'd0);
        expect_state("raw.after", 1'b1, 32'h0, 3'd0, 1'b0);

        // three stores against LSU_DEPTH=2
        next_cycle(); drv_store();
        expect_state("st.1", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); drv_store();
        expect_state("st.2", 1'b1, 32'h0, 3'd1, 1'b0);
        next_cycle(); drv_store();
        expect_state("st.3full", 1'b0, 32'h0, 3'd2, 1'b0);
        next_cycle(); drv_store(); sb_if.lsu_done_i = 1'b1;
        expect_state("st.pushpop", BYP, 32'h0, 3'd2, 1'b0);
        next_cycle(); sb_if.lsu_done_i = 1'b1;
        expect_state("st.drain1", 1'b1, 32'h0, BYP ? 3'd2 : 3'd1, 1'b0);
        next_cycle(); sb_if.lsu_done_i = 1'b1;
        expect_state("st.drain2", 1'b1, 32'h0, BYP ? 3'd1 : 3'd0, 1'b0);
        next_cycle();
        expect_state("st.empty", 1'b1, 32'h0, 3'd0, 1'b0);

        // MDU x7 then MDU x9: structural conflict until mdu_done
        next_cycle(); drv_mdu(5'd7);
        expect_state("mdu.1", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); drv_mdu(5'd9);
        expect_state("mdu.conf", 1'b0, 32'h80, 3'd0, 1'b1);
        next_cycle(); drv_mdu(5'd9); sb_if.mdu_done_i = 1'b1;
        expect_state("mdu.done", BYP, 32'h80, 3'd0, 1'b1);
        next_cycle(); drv_mdu(5'd9);
        expect_state("mdu.retry", ~BYP, BYP ? 32'h200 : 32'h0, 3'd0, BYP);
        next_cycle();
        expect_state("mdu.x9", 1'b1, 32'h200, 3'd0, 1'b1);
        next_cycle(); sb_if.mdu_done_i = 1'b1;
        expect_state("mdu.ret", 1'b1, 32'h200, 3'd0, 1'b1);
        next_cycle();
        expect_state("mdu.idle", 1'b1, 32'h0, 3'd0, 1'b0);

        // load to x0 is counted but tracks no register; pop on empty is ignored
        next_cycle(); drv_load(5'd0);
        expect_state("x0.ld", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle();
        expect_state("x0.cnt", 1'b1, 32'h0, 3'd1, 1'b0);
        next_cycle(); sb_if.lsu_done_i = 1'b1;
        expect_state("x0.pop", 1'b1, 32'h0, 3'd1, 1'b0);
        next_cycle(); sb_if.lsu_done_i = 1'b1; sb_if.mdu_done_i = 1'b1;
        expect_state("x0.emptypop", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle();
        expect_state("x0.after", 1'b1, 32'h0, 3'd0, 1'b0);

        // WAW on x3, then a killed instruction changes nothing
        next_cycle(); drv_load(5'd3);
        expect_state("waw.ld", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); drv_alu(5'd3, 5'd0, 5'd0);
        expect_state("waw.stall", 1'b0, 32'h8, 3'd1, 1'b0);
        next_cycle(); sb_if.lsu_done_i = 1'b1;
        expect_state("waw.done", 1'b1, 32'h8, 3'd1, 1'b0);
        next_cycle(); drv_load(5'd4); sb_if.kill_i = 1'b1;
        expect_state("kill", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle();
        expect_state("kill.after", 1'b1, 32'h0, 3'd0, 1'b0);

        // async reset with two loads and one MDU op in flight
        next_cycle(); drv_load(5'd1);
        expect_state("rst.ld1", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); drv_load(5'd2);
        expect_state("rst.ld2", 1'b1, 32'h2, 3'd1, 1'b0);
        next_cycle(); drv_mdu(5'd8);
        expect_state("rst.mdu", 1'b1, 32'h6, 3'd2, 1'b0);
        next_cycle(); drv_alu(5'd6, 5'd1, 5'd0);
        expect_state("rst.busy", 1'b0, 32'h106, 3'd2, 1'b1);
        #1;
        rst = 1'b1;
        expect_state("rst.async", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle(); rst = 1'b0; sb_if.lsu_done_i = 1'b1; sb_if.mdu_done_i = 1'b1;
        expect_state("rst.late", 1'b1, 32'h0, 3'd0, 1'b0);
        next_cycle();
        expect_state("rst.after", 1'b1, 32'h0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
